// File: rtl/pc_pkg.sv
// pc_pkg: shared operation encoding for the program-counter / return-stack unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pc_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_INC  = 3'd0;
  localparam op_t OP_JMP  = 3'd1;
  localparam op_t OP_BR   = 3'd2;
  localparam op_t OP_CALL = 3'd3;
  localparam op_t OP_RET  = 3'd4;
  // Encodings 5..7 are reserved and behave as OP_INC.

endpackage

// File: rtl/ras_stack.sv
// ras_stack: return-address LIFO of DEPTH x ADDR_W entries.
// Latency: push/pop take effect on the next rising clk edge; tos/full/empty decode registered state.
// Backpressure: none; a push while full or a pop while empty is silently ignored.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset (clears the count only)
//   push, pop       stack operations (issuing both in one cycle does nothing)
//   wdata           value pushed
//   tos             top entry, 0 when empty
//   depth_cnt       number of valid entries
//   full, empty     depth_cnt == DEPTH / depth_cnt == 0
module ras_stack
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] wdata,
  output logic [ADDR_W-1:0] tos,
  output logic [CW-1:0]     depth_cnt,
  output logic              full,
  output logic              empty
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     wr_idx;
  logic [IW-1:0]     top_idx;
  logic              do_push;
  logic              do_pop;

  assign full      = (cnt == CW'(DEPTH));
  assign empty     = (cnt == '0);
  assign depth_cnt = cnt;

  assign do_push = push && !full && !pop;
  assign do_pop  = pop && !empty && !push;

  // The count is also the index of the next free slot; the top sits one below it.
  assign wr_idx  = IW'(cnt);
  assign top_idx = IW'(cnt - CW'(1));

  assign tos = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (do_push) begin
      cnt <= cnt + CW'(1);
    end else if (do_pop) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Entries are never cleared; a reset only empties the stack logically.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem[wr_idx] <= wdata;
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with INC/JMP/BR/CALL/RET and an internal return-address stack.
// Latency: op sampled at edge N is visible on pc/tos/depth_cnt after edge N; no op->pc comb path.
// Backpressure: stall=1 freezes pc and stack (err_clr still honoured); no ready/valid handshake.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   stall                 hold all PC/stack state, ignore op
//   op, target, offset    operation from the decoder, JMP/CALL destination, BR displacement
//   pc                    registered program counter
//   tos, depth_cnt        return-stack top entry (0 when empty) and occupancy
//   full, empty           return-stack status
//   err_ovf, err_unf      sticky CALL-while-full / RET-while-empty flags
//   err_clr               clears both sticky flags (a same-cycle new error wins)
module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       STEP      = 1,
  parameter int unsigned       DEPTH     = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  localparam int unsigned      CW        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  op_t               op,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] offset,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] tos,
  output logic [CW-1:0]     depth_cnt,
  output logic              full,
  output logic              empty,
  output logic              err_ovf,
  output logic              err_unf,
  input  logic              err_clr
);

  localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);

  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] ret_addr;
  logic              push;
  logic              pop;
  logic              set_ovf;
  logic              set_unf;

  assign ret_addr = pc + STEP_W;

  // Failing CALL/RET leave pc where it is and only raise the matching flag.
  // BR adds the raw offset bits: modulo-2^ADDR_W addition of a two's-complement
  // value is the same as a signed add with wrap.
  always_comb begin
    pc_nxt  = pc;
    push    = 1'b0;
    pop     = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (!stall) begin
      case (op)
        OP_JMP: pc_nxt = target;
        OP_BR:  pc_nxt = pc + offset;
        OP_CALL: begin
          if (full) begin
            set_ovf = 1'b1;
          end else begin
            push   = 1'b1;
            pc_nxt = target;
          end
        end
        OP_RET: begin
          if (empty) begin
            set_unf = 1'b1;
          end else begin
            pop    = 1'b1;
            pc_nxt = tos;
          end
        end
        default: pc_nxt = ret_addr;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_VEC;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      pc      <= pc_nxt;
      err_ovf <= set_ovf | (err_ovf & ~err_clr);
      err_unf <= set_unf | (err_unf & ~err_clr);
    end
  end

  ras_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push && !reset),
    .pop       (pop && !reset),
    .wdata     (ret_addr),
    .tos       (tos),
    .depth_cnt (depth_cnt),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: directed stimulus, queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_pc_stack_unit;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned STEP   = 1;
  localparam int unsigned DEPTH  = 8;
  localparam logic [15:0] RV     = 16'h0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [15:0] target = '0;
  logic [15:0] offset = '0;
  logic        err_clr = 1'b0;
  logic [15:0] pc;
  logic [15:0] tos;
  logic [3:0]  depth_cnt;
  logic        full;
  logic        empty;
  logic        err_ovf;
  logic        err_unf;

  pc_stack_unit #(
    .ADDR_W    (ADDR_W),
    .STEP      (STEP),
    .DEPTH     (DEPTH),
    .RESET_VEC (RV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .op        (op),
    .target    (target),
    .offset    (offset),
    .pc        (pc),
    .tos       (tos),
    .depth_cnt (depth_cnt),
    .full      (full),
    .empty     (empty),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] m_pc;
  logic [15:0] m_stk [$];
  logic        m_ovf;
  logic        m_unf;
  bit          check_en = 1'b0;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One clock: drive inputs, let the edge happen, then advance the model
  // from the same inputs using the architectural rules.
  task automatic cyc(input logic [2:0] o, input logic [15:0] t, input logic [15:0] off,
                     input logic s, input logic r, input logic c);
    logic [15:0] npc;
    op = o; target = t; offset = off; stall = s; reset = r; err_clr = c;
    @(posedge clk);
    #1;
    if (r) begin
      m_pc = RV;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      npc = m_pc;
      if (c) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (!s) begin
        case (o)
          3'd1: npc = t;
          3'd2: npc = 16'(m_pc + off);
          3'd3: begin
            if (m_stk.size() == DEPTH) m_ovf = 1'b1;
            else begin
              m_stk.push_back(16'(m_pc + 16'(STEP)));
              npc = t;
            end
          end
          3'd4: begin
            if (m_stk.size() == 0) m_unf = 1'b1;
            else npc = m_stk.pop_back();
          end
          default: npc = 16'(m_pc + 16'(STEP));
        endcase
      end
      m_pc = npc;
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("pc", 32'(pc), 32'(m_pc));
      chk("tos", 32'(tos), (m_stk.size() == 0) ? 32'd0 : 32'(m_stk[$]));
      chk("depth_cnt", 32'(depth_cnt), 32'(m_stk.size()));
      chk("full", 32'(full), 32'(m_stk.size() == DEPTH));
      chk("empty", 32'(empty), 32'(m_stk.size() == 0));
      chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
      chk("err_unf", 32'(err_unf), 32'(m_unf));
    end
  end

  initial begin
    // Reset, then three increments from the reset vector
    cyc(3'd0, '0, '0, 1'b0, 1'b1, 1'b0);
    check_en = 1'b1;
    chk("reset_pc", 32'(pc), 32'h0100);
    chk("reset_depth", 32'(depth_cnt), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_errs", {30'd0, err_ovf, err_unf}, 32'd0);
    cyc(3'd0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("inc1", 32'(pc), 32'h0101);
    cyc(3'd0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("inc2", 32'(pc), 32'h0102);
    cyc(3'd0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("inc3", 32'(pc), 32'h0103);
    chk("inc_depth", 32'(depth_cnt), 32'd0);

    // Branch backwards, wrap on increment, absolute jump, forward branch
    cyc(3'd1, 16'h0010, '0, 1'b0, 1'b0, 1'b0);
    cyc(3'd2, '0, 16'hFFF0, 1'b0, 1'b0, 1'b0);
    chk("br_neg", 32'(pc), 32'h0000);
    cyc(3'd1, 16'hFFFF, '0, 1'b0, 1'b0, 1'b0);
    cyc(3'd0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("inc_wrap", 32'(pc), 32'h0000);
    cyc(3'd1, 16'h1234, '0, 1'b0, 1'b0, 1'b0);
    chk("jmp", 32'(pc), 32'h1234);
    cyc(3'd2, '0, 16'h0005, 1'b0, 1'b0, 1'b0);
    chk("br_pos", 32'(pc), 32'h1239);

    // Nested call / return
    cyc(3'd1, 16'h0020, '0, 1'b0, 1'b0, 1'b0);
    cyc(3'd3, 16'h0400, '0, 1'b0, 1'b0, 1'b0);
    chk("call1_pc", 32'(pc), 32'h0400);
    chk("call1_tos", 32'(tos), 32'h0021);
    chk("call1_depth", 32'(depth_cnt), 32'd1);
    cyc(3'd3, 16'h0800, '0, 1'b0, 1'b0, 1'b0);
    chk("call2_tos", 32'(tos), 32'h0401);
    cyc(3'd4, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("ret1_pc", 32'(pc), 32'h0401);
    cyc(3'd4, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("ret2_pc", 32'(pc), 32'h0021);
    chk("ret2_empty", 32'(empty), 32'd1);

    // Fill the stack, reserved op acts as INC, overflow, drain, underflow
    for (int i = 0; i < 8; i++) cyc(3'd3, 16'(16'h1000 + i * 16), '0, 1'b0, 1'b0, 1'b0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_pc", 32'(pc), 32'h1070);
    cyc(3'd7, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("reserved_inc", 32'(pc), 32'h1071);
    cyc(3'd3, 16'h2000, '0, 1'b0, 1'b0, 1'b0);
    chk("ovf_pc", 32'(pc), 32'h1071);
    chk("ovf_depth", 32'(depth_cnt), 32'd8);
    chk("ovf_flag", 32'(err_ovf), 32'd1);
    for (int i = 0; i < 8; i++) cyc(3'd4, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("drain_pc", 32'(pc), 32'h0022);
    chk("drain_empty", 32'(empty), 32'd1);
    cyc(3'd4, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("unf_flag", 32'(err_unf), 32'd1);
    chk("unf_pc", 32'(pc), 32'h0022);
    chk("ovf_sticky", 32'(err_ovf), 32'd1);

    // Clear during stall, then clear racing a fresh underflow
    cyc(3'd0, '0, '0, 1'b1, 1'b0, 1'b1);
    chk("clr_flags", {30'd0, err_ovf, err_unf}, 32'd0);
    chk("clr_stall_pc", 32'(pc), 32'h0022);
    cyc(3'd4, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("clr_vs_set", 32'(err_unf), 32'd1);

    // Stalled CALLs do nothing; reset discards an in-flight CALL
    cyc(3'd3, 16'h3000, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(3'd3, 16'h5000, '0, 1'b1, 1'b0, 1'b0);
    chk("stall_pc", 32'(pc), 32'h3000);
    chk("stall_depth", 32'(depth_cnt), 32'd1);
    cyc(3'd3, 16'h6000, '0, 1'b0, 1'b1, 1'b0);
    chk("rst_call_pc", 32'(pc), 32'h0100);
    chk("rst_call_depth", 32'(depth_cnt), 32'd0);
    chk("rst_call_errs", {30'd0, err_ovf, err_unf}, 32'd0);
    cyc(3'd0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_inc", 32'(pc), 32'h0101);

    @(negedge clk);
    check_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised program-counter unit for the sequencer datapath.
- Next generation of the plain load/increment PC: configurable width, step and reset vector.
- Adds PC-relative branch and an internal return-address stack (CALL/RET) with full/empty status and sticky overflow/underflow error flags.
- Sits between the instruction decoder (which drives `op`, `target` and `offset`) and instruction memory (which is addressed by `pc`).

Parameters:
- ADDR_W, 16: width of the PC, target, offset and stack entries.
- STEP, 1: increment applied by INC and by the CALL return-address computation.
- DEPTH, 8: number of return-stack entries. Must be ≥2; power of two not required.
- RESET_VEC, 0: PC value after reset.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  when high, holds all state; `op` is ignored.
- op  in  3  operation: 0 INC, 1 JMP, 2 BR, 3 CALL, 4 RET; 5-7 reserved, treated as INC.
- target  in  ADDR_W  absolute destination for JMP and CALL.
- offset  in  ADDR_W  two's-complement displacement for BR.
- pc  out  ADDR_W  current program counter (registered).
- tos  out  ADDR_W  top-of-stack entry; 0 when empty.
- depth_cnt  out  $clog2(DEPTH+1)  number of valid stack entries.
- full  out  1  depth_cnt == DEPTH.
- empty  out  1  depth_cnt == 0.
- err_ovf  out  1  sticky: CALL attempted while full.
- err_unf  out  1  sticky: RET attempted while empty.
- err_clr  in  1  clears both sticky error flags.

Behaviour:
- Priority per edge: reset > stall > op.
- Reset, synchronous on a rising clk edge with reset=1:
  - pc=RESET_VEC, depth_cnt=0, err_ovf=0, err_unf=0.
  - Stack array contents are not cleared.
  - Reset mid-CALL/RET discards that operation.
- stall=1: pc, stack pointer and stack array hold; err_clr is still honoured.
- Latency: the op sampled at edge N is visible on pc, tos and depth_cnt after edge N. No combinational path from op to pc.
- INC: pc <= pc + STEP, modulo 2^ADDR_W (0xFFFF + 1 wraps to 0x0000 at ADDR_W=16).
- JMP: pc <= target.
- BR: pc <= pc + offset, offset sign-interpreted, result modulo 2^ADDR_W.
- CALL, not full: push (pc + STEP) mod 2^ADDR_W; pc <= target; depth_cnt+1.
- CALL, full: no push, pc holds, err_ovf <= 1.
- RET, not empty: pc <= tos; pop; depth_cnt-1.
- RET, empty: pc holds, err_unf <= 1.
- tos, full and empty are combinational decodes of registered state only.
- err_clr in the same cycle as a new error: the set wins and the flag stays 1.
- Errors never alter stack contents.

Decomposition:
- Package pc_pkg:
  - op encoding constants OP_INC, OP_JMP, OP_BR, OP_CALL, OP_RET.
  - op type of width 3.
- Sub-module ras_stack: LIFO of DEPTH × ADDR_W.
  - Inputs: push, pop, wdata.
  - Outputs: tos, depth_cnt, full, empty.
  - Pointer logic and reset live inside it.
  - It ignores a push when full and a pop when empty. pc_stack_unit gates both and raises the errors.

Test Plan:
- Reset then 3× INC with STEP=1, RESET_VEC=0x0100 → pc 0x0100, 0x0101, 0x0102, 0x0103; depth_cnt=0, empty=1.
- pc=0x0010: BR with offset=0xFFF0 → pc=0x0000. Then INC from pc=0xFFFF → pc=0x0000. Then JMP target=0x1234 → pc=0x1234.
- pc=0x0020: CALL 0x0400 → pc=0x0400, tos=0x0021, depth_cnt=1. Then CALL 0x0800 → tos=0x0401. Then RET → pc=0x0401; RET → pc=0x0021; empty=1.
- DEPTH=8: 8 CALLs → full=1. 9th CALL → pc unchanged, depth_cnt=8, err_ovf=1. RET on empty → err_unf=1, pc unchanged.
- Errors: err_clr for one cycle → both flags 0. err_clr asserted together with a failing RET → err_unf remains 1.
- stall=1 with op=CALL for 3 cycles → pc and depth_cnt unchanged. reset asserted during CALL → pc=RESET_VEC, depth_cnt=0, errors 0.
